// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
// Holds the FSM state encoding, parity-mode codes and the default divider.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int CLK_DIV_DEF = 2604;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts while en is high, pulses bit_end on CLK_DIV-1.
// Held at zero while disabled so every frame starts on a fresh period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_W bits LSB first, optional parity, stops.
// Parity generation exists only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PAR_NONE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              rdy,
  output logic              dout,
  output logic              frame_done
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic STP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 8 || CLK_DIV < 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY < 0 || PARITY > 2) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter set");
  end

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              stp_q, stp_d;
  logic              dout_q, dout_d;
  logic              fd_q, fd_d;
  logic              bit_end;
  logic              en;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam bit PAR_INV = (PARITY == PAR_ODD);

  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (state_q == S_IDLE && din_vld) begin
      par_d = (^din) ^ PAR_INV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign en = (state_q != S_IDLE);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    stp_d   = stp_q;
    fd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (din_vld) begin
          state_d = S_START;
          sh_d    = din;
          idx_d   = '0;
          stp_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PAR_ON ? S_PAR : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
            sh_d  = sh_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (stp_q == STP_LAST) begin
            state_d = S_IDLE;
            stp_d   = 1'b0;
            fd_d    = 1'b1;
          end else begin
            stp_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so dout is a clean flop.
  always_comb begin
    dout_d = 1'b1;
    unique case (state_d)
      S_START: dout_d = 1'b0;
      S_DATA:  dout_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   dout_d = par_q;
`endif
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      stp_q   <= 1'b0;
      dout_q  <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      stp_q   <= stp_d;
      dout_q  <= dout_d;
      fd_q    <= fd_d;
    end
  end

  assign rdy        = (state_q == S_IDLE);
  assign dout       = dout_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: bit timing, stop bits, back-to-back,
// ignored valid, mid-frame reset and (with UART_TX_PARITY_EN) parity.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NDUT = 4;
`else
  localparam int NDUT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din  [4];
  logic       vld  [4];
  logic       dout [4];
  logic       rdy  [4];
  logic       fd   [4];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_W(8), .CLK_DIV(DIV), .STOP_BITS(1), .PARITY(PAR_NONE)
  ) u_s1 (
    .clk(clk), .rst(rst), .din(din[0]), .din_vld(vld[0]),
    .rdy(rdy[0]), .dout(dout[0]), .frame_done(fd[0])
  );

  uart_tx_frame #(
    .DATA_W(8), .CLK_DIV(DIV), .STOP_BITS(2), .PARITY(PAR_NONE)
  ) u_s2 (
    .clk(clk), .rst(rst), .din(din[1]), .din_vld(vld[1]),
    .rdy(rdy[1]), .dout(dout[1]), .frame_done(fd[1])
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_frame #(
    .DATA_W(8), .CLK_DIV(DIV), .STOP_BITS(1), .PARITY(PAR_EVEN)
  ) u_pe (
    .clk(clk), .rst(rst), .din(din[2]), .din_vld(vld[2]),
    .rdy(rdy[2]), .dout(dout[2]), .frame_done(fd[2])
  );

  uart_tx_frame #(
    .DATA_W(8), .CLK_DIV(DIV), .STOP_BITS(1), .PARITY(PAR_ODD)
  ) u_po (
    .clk(clk), .rst(rst), .din(din[3]), .din_vld(vld[3]),
    .rdy(rdy[3]), .dout(dout[3]), .frame_done(fd[3])
  );
`else
  assign dout[2] = 1'b1;
  assign dout[3] = 1'b1;
  assign rdy[2]  = 1'b1;
  assign rdy[3]  = 1'b1;
  assign fd[2]   = 1'b0;
  assign fd[3]   = 1'b0;
`endif

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller sits just after a negedge with the DUT idle.
  // pmode: 0 none, 1 even, 2 odd. inj: frame cycle to pulse a 0xFF valid.
  task automatic run_frame(int k, logic [7:0] data, logic [7:0] after,
                           bit keep, int nstop, int pmode, int inj);
    logic bits[$];
    int   cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pmode == 1) bits.push_back(^data);
    if (pmode == 2) bits.push_back(~^data);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    chk($sformatf("rdy_pre d%0d %h", k, data), 32'(rdy[k]), 32'd1);
    din[k] = data;
    vld[k] = 1'b1;
    @(posedge clk);
    #1;
    din[k] = after;
    if (!keep) vld[k] = 1'b0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        cyc = b * DIV + c;
        chk($sformatf("dout d%0d %h c%0d", k, data, cyc),
            32'(dout[k]), 32'(bits[b]));
        chk($sformatf("fd_lo d%0d %h c%0d", k, data, cyc),
            32'(fd[k]), 32'd0);
        if (cyc == 0)
          chk($sformatf("rdy_lo d%0d %h", k, data), 32'(rdy[k]), 32'd0);
        if (inj >= 0 && cyc == inj) begin
          vld[k] = 1'b1;
          din[k] = 8'hFF;
        end
        if (inj >= 0 && cyc == inj + 1) begin
          vld[k] = 1'b0;
          din[k] = after;
        end
      end
    end
    @(negedge clk);
    chk($sformatf("fd_hi d%0d %h", k, data), 32'(fd[k]), 32'd1);
    chk($sformatf("rdy_end d%0d %h", k, data), 32'(rdy[k]), 32'd1);
    chk($sformatf("dout_end d%0d %h", k, data), 32'(dout[k]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din[k] = 8'h00;
      vld[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_dout d%0d", k), 32'(dout[k]), 32'd1);
      chk($sformatf("rst_rdy d%0d", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("rst_fd d%0d", k), 32'(fd[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 8'hA5, 8'h00, 1'b0, 1, 0, -1);
    @(negedge clk);
    chk("fd_one_cycle", 32'(fd[0]), 32'd0);

    run_frame(0, 8'h11, 8'h22, 1'b1, 1, 0, -1);
    run_frame(0, 8'h22, 8'h00, 1'b0, 1, 0, -1);
    @(negedge clk);

    run_frame(0, 8'h3C, 8'h00, 1'b0, 1, 0, 10);
    @(negedge clk);

    run_frame(1, 8'h00, 8'h00, 1'b0, 2, 0, -1);
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    run_frame(2, 8'h07, 8'h00, 1'b0, 1, 1, -1);
    @(negedge clk);
    run_frame(3, 8'h07, 8'h00, 1'b0, 1, 2, -1);
    @(negedge clk);
`endif

    din[0] = 8'h96;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst_bit3", 32'(dout[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(dout[0]), 32'd1);
    chk("mid_rst_rdy", 32'(rdy[0]), 32'd1);
    chk("mid_rst_fd", 32'(fd[0]), 32'd0);
    din[0] = 8'h5A;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ign_rdy", 32'(rdy[0]), 32'd1);
    chk("rst_ign_dout", 32'(dout[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 8'h5A, 8'h00, 1'b0, 1, 0, -1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
